icache_refill_server: RTL and testbench
=======================================

# icache_refill_server

Memory-side responder for the I_cache refill port. On `mem_r` it fetches the 16-byte line containing `mem_addr` as four 32-bit beats from a word-wide memory bus. It then returns the whole line on `mem_data` with a one-cycle `mem_ready` pulse. It sits between the I_cache and the instruction memory/bus arbiter in the PCPU fetch path.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `bus_ack` on one beat before the line is aborted with error. Range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `mem_r` in 1: refill request from the cache; level, held until `mem_ready` is seen.
- `mem_addr` in 32: refill address; only `[31:4]` is used.
- `mem_ready` out 1: one-cycle pulse; line (or error) returned.
- `mem_data` out 128: line data; word k in `[32k+31:32k]`.
- `mem_err` out 1: valid with `mem_ready`; 1 means timeout or bus error.
- `bus_req` out 1: beat request, held until ack.
- `bus_addr` out 32: beat word address, stable while `bus_req`=1.
- `bus_ack` in 1: beat complete; `bus_rdata`/`bus_err` valid this cycle.
- `bus_rdata` in 32: beat read data.
- `bus_err` in 1: beat failed; qualified by `bus_ack`.

## Operation
- FSM states: IDLE, FETCH, DONE, DRAIN.
- IDLE: if `mem_r`=1, capture `mem_addr[31:4]` into the line register, clear beat index k=0, clear `mem_data`, go to FETCH.
- FETCH:
  - `bus_req`=1 and `bus_addr`={line,k[1:0],2'b00}.
  - On `bus_ack` with `bus_err`=0: write `bus_rdata` to word k.
    - If k=3, go to DONE with err=0.
    - Otherwise k++, and `bus_req` stays high with the next address on the following cycle.
  - On `bus_ack` with `bus_err`=1: go to DONE with err=1; the remaining words stay 0.
- Timeout: a per-beat counter resets on each new beat. If the counter reaches `TIMEOUT` cycles without `bus_ack`, drop `bus_req` and go to DONE with err=1.
- Abort: if `mem_r` is sampled 0 during FETCH, the current beat still completes or times out, because the bus cannot be cancelled. The block then goes to IDLE with no `mem_ready`.
- DONE: `mem_ready`=1 for exactly one cycle, `mem_err`=err, then go to DRAIN.
- DRAIN: wait until `mem_r`=0, then go to IDLE. This stops a still-high `mem_r` from re-triggering a refill of the same line.
- `mem_data` and `mem_err` hold their values from DONE until the next IDLE accept.
- Beat order is always word 0..3. There is no critical-word-first; the cache selects the word using `addr[3:2]`.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, and `mem_ready`, `mem_err`, `mem_data`, `bus_req`, `bus_addr` are all 0.
- Reset mid-FETCH drops `bus_req` on that edge; the bus slave must tolerate a withdrawn request.
- All outputs are registered.
- Accept at edge T; `bus_req` is high from T+1.
- `bus_ack` may arrive in any cycle `bus_req`=1, including the first cycle.
- With zero-wait acks, beats complete in cycles T+1..T+4 and `mem_ready`=1 in cycle T+5. Minimum latency is 5 cycles; each wait state adds 1.
- `bus_ack` while `bus_req`=0 is ignored.
- The earliest re-accept is 2 cycles after `mem_ready`, provided `mem_r` drops in the cycle after `mem_ready`.

## Test plan
- Basic refill: `mem_addr`=0x5a5a5ffc, zero-wait slave returning 0x11111111, 0x22222222, 0x33333333, 0x44444444. Required: `bus_addr` sequence 0x5a5a5ff0, ff4, ff8, ffc; `mem_ready` at T+5 with `mem_data`=0x44444444_33333333_22222222_11111111 and `mem_err`=0.
- Wait states: slave inserts 3 wait cycles on beat 2. Required: `bus_addr`=0x…ff8 held stable for 4 cycles; `mem_ready` at T+8.
- Held request: `mem_r` kept at 1 for 10 cycles after `mem_ready`. Required: exactly one `mem_ready`, no new `bus_req`; a new request is accepted 1 cycle after `mem_r` falls.
- Errors:
  - Timeout case: `TIMEOUT`=4, slave never acks beat 1. Required: `bus_req` drops after 4 cycles; `mem_ready`=1, `mem_err`=1, with word 0 valid and words 1..3 = 0.
  - Bus-error case: `bus_err`=1 on beat 0. Required: `mem_err`=1 and `mem_data`=0.
- Abort and reset:
  - Abort case: `mem_r` drops during beat 1 with 2 wait cycles. Required: beat 1 completes, no beats 2/3, no `mem_ready`, state returns to IDLE.
  - Reset case: `rst`=0 mid-beat. Required: all outputs 0 on the next edge.

Source files
------------

// File: rtl/icache_refill_server.sv
// icache_refill_server: memory-side responder for the I-cache refill port.
// Fetches a 16-byte line as four word beats (word 0..3) from a word-wide
// bus and returns it with a one-cycle mem_ready pulse, flagging timeout or
// bus errors on mem_err. All outputs are registered.
module icache_refill_server #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_r,
    input  logic [31:0]  mem_addr,
    output logic         mem_ready,
    output logic [127:0] mem_data,
    output logic         mem_err,
    output logic         bus_req,
    output logic [31:0]  bus_addr,
    input  logic         bus_ack,
    input  logic [31:0]  bus_rdata,
    input  logic         bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Last count value of a beat before it is declared timed out.
    localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

    state_t       state, state_next;
    logic [27:0]  line, line_next;
    logic [1:0]   beat, beat_next;
    logic [7:0]   timer, timer_next;
    logic         abort, abort_next;
    logic         mem_ready_next;
    logic [127:0] mem_data_next;
    logic         mem_err_next;
    logic         bus_req_next;
    logic [31:0]  bus_addr_next;
    logic         quit;
    logic         beat_ack;

    // Only the line address is used; the byte/word offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[3:0];

    // Register state and all registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            line      <= '0;
            beat      <= '0;
            timer     <= '0;
            abort     <= 1'b0;
            mem_ready <= 1'b0;
            mem_data  <= '0;
            mem_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
        end else begin
            state     <= state_next;
            line      <= line_next;
            beat      <= beat_next;
            timer     <= timer_next;
            abort     <= abort_next;
            mem_ready <= mem_ready_next;
            mem_data  <= mem_data_next;
            mem_err   <= mem_err_next;
            bus_req   <= bus_req_next;
            bus_addr  <= bus_addr_next;
        end
    end

    // Next-state and next-output logic for the refill sequence.
    always_comb begin
        state_next     = state;
        line_next      = line;
        beat_next      = beat;
        timer_next     = timer;
        abort_next     = abort;
        mem_ready_next = 1'b0;
        mem_data_next  = mem_data;
        mem_err_next   = mem_err;
        bus_req_next   = bus_req;
        bus_addr_next  = bus_addr;
        // A dropped request is remembered; the in-flight beat still finishes.
        quit           = abort | ~mem_r;
        // An ack only counts while a beat is actually requested.
        beat_ack       = bus_ack & bus_req;

        case (state)
            IDLE: begin
                abort_next = 1'b0;
                if (mem_r) begin
                    line_next     = mem_addr[31:4];
                    beat_next     = 2'd0;
                    timer_next    = '0;
                    mem_data_next = '0;
                    mem_err_next  = 1'b0;
                    bus_req_next  = 1'b1;
                    bus_addr_next = {mem_addr[31:4], 4'b0000};
                    state_next    = FETCH;
                end
            end

            FETCH: begin
                abort_next = quit;
                if (beat_ack) begin
                    timer_next = '0;
                    if (!bus_err) begin
                        mem_data_next[{beat, 5'b00000} +: 32] = bus_rdata;
                    end
                    if (bus_err || beat == 2'd3) begin
                        bus_req_next = 1'b0;
                        if (quit) begin
                            state_next = IDLE;
                        end else begin
                            mem_ready_next = 1'b1;
                            mem_err_next   = bus_err;
                            state_next     = DONE;
                        end
                    end else if (quit) begin
                        bus_req_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        beat_next     = beat + 2'd1;
                        bus_addr_next = {line, beat + 2'd1, 2'b00};
                    end
                end else if (timer == TIMER_MAX) begin
                    timer_next   = '0;
                    bus_req_next = 1'b0;
                    if (quit) begin
                        state_next = IDLE;
                    end else begin
                        mem_ready_next = 1'b1;
                        mem_err_next   = 1'b1;
                        state_next     = DONE;
                    end
                end else begin
                    timer_next = timer + 8'd1;
                end
            end

            DONE: begin
                state_next = DRAIN;
            end

            DRAIN: begin
                // Hold off until the cache lets go of the request.
                if (!mem_r) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill_server.sv
// Self-checking bench for icache_refill_server: directed cases followed by
// randomized refills, each compared cycle by cycle against a line-level model.
module tb_icache_refill_server;

    localparam int TO    = 4;
    localparam int NEVER = 99;

    logic         clk;
    logic         rst;
    logic         mem_r;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_data;
    logic         mem_err;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_ack;
    logic [31:0]  bus_rdata;
    logic         bus_err;

    int checks = 0;
    int errors = 0;

    // Plan for the next refill.
    logic [31:0] cur_addr;
    logic [31:0] words [4];
    int          wait_plan [4];
    logic        err_plan [4];
    int          abort_c;
    int          hold;

    icache_refill_server #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r     (mem_r),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_plan();
        cur_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            words[i]     = $urandom;
            wait_plan[i] = 0;
            err_plan[i]  = 1'b0;
        end
        abort_c = 0;
        hold    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mem_ready"}, 128'(mem_ready), 128'(0));
        check_val({tag, "_mem_err"},   128'(mem_err),   128'(0));
        check_val({tag, "_mem_data"},  mem_data,        128'(0));
        check_val({tag, "_bus_req"},   128'(bus_req),   128'(0));
        check_val({tag, "_bus_addr"},  128'(bus_addr),  128'(0));
    endtask

    // One refill: model predicts the whole cycle-level picture from the plan,
    // then the bench plays requester and bus slave and compares every cycle.
    task automatic run_refill();
        logic         exp_req  [64];
        logic [31:0]  exp_addr [64];
        logic         exp_rdy  [64];
        logic [127:0] exp_data;
        logic         exp_err;
        int           cyc, dur, end_c, rdy_c, drop_c, last_c, s_beat, s_wait;
        bit           aborted, to, be;

        for (int i = 0; i < 64; i++) begin
            exp_req[i]  = 1'b0;
            exp_addr[i] = '0;
            exp_rdy[i]  = 1'b0;
        end
        exp_data = '0;
        exp_err  = 1'b0;
        aborted  = 1'b0;
        cyc      = 1;
        end_c    = 0;
        for (int i = 0; i < 4; i++) begin
            to  = (wait_plan[i] >= TO);
            dur = to ? TO : wait_plan[i] + 1;
            for (int j = 0; j < dur; j++) begin
                exp_req[cyc + j]  = 1'b1;
                exp_addr[cyc + j] = {cur_addr[31:4], 4'(i * 4)};
            end
            end_c = cyc + dur - 1;
            be    = !to && err_plan[i];
            if (!to && !be) exp_data[i*32 +: 32] = words[i];
            cyc = end_c + 1;
            if (abort_c > 0 && abort_c <= end_c) begin
                aborted = 1'b1;
                break;
            end
            if (to || be) begin
                exp_err = 1'b1;
                break;
            end
        end
        if (aborted) begin
            rdy_c  = 0;
            drop_c = abort_c;
            last_c = end_c + 2;
        end else begin
            exp_rdy[cyc] = 1'b1;
            rdy_c  = cyc;
            drop_c = rdy_c + 1 + hold;
            last_c = drop_c;
        end

        @(negedge clk);
        mem_r    = 1'b1;
        mem_addr = cur_addr;
        bus_ack  = 1'b0;
        s_beat   = 0;
        s_wait   = 0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            if (c == drop_c) mem_r = 1'b0;
            check_val("bus_req", 128'(bus_req), 128'(exp_req[c]));
            if (exp_req[c]) check_val("bus_addr", 128'(bus_addr), 128'(exp_addr[c]));
            check_val("mem_ready", 128'(mem_ready), 128'(exp_rdy[c]));
            if (c == rdy_c) begin
                check_val("mem_data", mem_data, exp_data);
                check_val("mem_err", 128'(mem_err), 128'(exp_err));
            end
            if (bus_req && s_beat < 4 && s_wait == wait_plan[s_beat]) begin
                bus_ack   = 1'b1;
                bus_rdata = words[s_beat];
                bus_err   = err_plan[s_beat];
                s_beat++;
                s_wait = 0;
            end else if (bus_req) begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
                bus_err   = 1'($urandom);
                s_wait++;
            end else begin
                // Acks with no request outstanding must be ignored.
                bus_ack   = 1'($urandom);
                bus_rdata = $urandom;
                bus_err   = 1'($urandom);
            end
        end
        if (!aborted) begin
            check_val("mem_data_hold", mem_data, exp_data);
            check_val("mem_err_hold", 128'(mem_err), 128'(exp_err));
        end
    endtask

    initial begin
        rst       = 1'b0;
        mem_r     = 1'b0;
        mem_addr  = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        bus_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic zero-wait refill.
        clear_plan();
        cur_addr = 32'h5a5a5ffc;
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;
        run_refill();

        // Three wait states on beat 2.
        clear_plan();
        cur_addr     = 32'h5a5a5ffc;
        wait_plan[2] = 3;
        run_refill();

        // Request held high for 10 cycles after mem_ready.
        clear_plan();
        cur_addr = 32'h0000_1234;
        hold     = 10;
        run_refill();

        // Beat 1 never acked: timeout.
        clear_plan();
        cur_addr     = 32'hcafe_0008;
        wait_plan[1] = NEVER;
        run_refill();

        // Bus error on beat 0.
        clear_plan();
        cur_addr    = 32'h8000_0010;
        err_plan[0] = 1'b1;
        run_refill();

        // Request dropped during beat 1 which has two wait cycles.
        clear_plan();
        cur_addr     = 32'h0bad_f00c;
        wait_plan[1] = 2;
        abort_c      = 3;
        run_refill();

        // Recovery after abort.
        clear_plan();
        cur_addr = 32'h1357_9bd0;
        run_refill();

        // Reset in the middle of an unacked beat.
        @(negedge clk);
        mem_r    = 1'b1;
        mem_addr = 32'h2468_ace0;
        bus_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("pre_reset_bus_req", 128'(bus_req), 128'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst   = 1'b1;
        mem_r = 1'b0;

        // Randomized refills.
        for (int n = 0; n < 40; n++) begin
            clear_plan();
            cur_addr = $urandom;
            for (int i = 0; i < 4; i++) begin
                wait_plan[i] = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 3));
                err_plan[i]  = ($urandom_range(0, 15) == 0);
            end
            abort_c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0;
            hold    = int'($urandom_range(0, 3));
            run_refill();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
